mips_bus_demux3: RTL and testbench
==================================

MIPS_BUS_DEMUX3 -- requirements
Module: mips_bus_demux3

Interface
REQ-001 Parameter WIDTH, default 32: data bus width in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: cycles allowed for a target Ack when the timeout feature is compiled in.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 Req  input  1  initiator request strobe, sampled in IDLE only.
REQ-006 Addr  input  32  initiator byte address.
REQ-007 WData  input  WIDTH  initiator write data.
REQ-008 WE  input  1  1 = write, 0 = read.
REQ-009 RData  output  WIDTH  read data returned to the initiator.
REQ-010 Ack  output  1  one-cycle completion pulse to the initiator.
REQ-011 Err  output  1  qualifies Ack; 1 = decode error or timeout.
REQ-012 Busy  output  1  1 while a transaction is outstanding.
REQ-013 Tgt_Req  output  3  one-hot request: bit0 = RAM, bit1 = IO, bit2 = timer.
REQ-014 Tgt_Addr  output  32, Tgt_WData  output  WIDTH, Tgt_WE  output  1: latched transaction fields, broadcast to all targets.
REQ-015 Tgt_RData_A, Tgt_RData_B, Tgt_RData_C  input  WIDTH each: read data from RAM, IO and timer.
REQ-016 Tgt_Ack  input  3  per-target completion, same bit order as Tgt_Req.

Function
REQ-017 Decode uses Addr[31:28]: 4'h0 selects RAM, 4'h1 selects IO, 4'h2 selects timer; every other value is a decode error.
REQ-018 FSM states: IDLE, ISSUE, RESP.
- IDLE -> ISSUE on Req=1 with a valid decode.
- IDLE -> RESP on Req=1 with a decode error.
REQ-019 On leaving IDLE, the module latches Addr, WData, WE and the decoded select; the initiator need not hold these fields afterwards.
REQ-020 In ISSUE, exactly one Tgt_Req bit, the latched select, is 1 and is held until the selected Tgt_Ack bit is sampled at 1; all other states drive Tgt_Req = 3'b000.
REQ-021 When the selected Tgt_Ack is sampled at 1 in ISSUE:
- capture the matching Tgt_RData_x on a read, or 0 on a write;
- go to RESP.
REQ-022 RESP lasts exactly one cycle with Ack=1, then the FSM returns to IDLE; Ack is 0 in every other state.
REQ-023 Minimum latency: Req in cycle N, Tgt_Req in cycle N+1, Tgt_Ack in cycle N+1, Ack in cycle N+2.
REQ-024 Decode error: Ack=1, Err=1, RData=0 in cycle N+1; no Tgt_Req bit is asserted.
REQ-025 Tgt_Ack bits of non-selected targets, and any Tgt_Ack outside ISSUE, are ignored.
REQ-026 Busy = 1 in ISSUE and RESP; a Req while Busy=1 is ignored, not queued.
REQ-027 RData and Err hold their values until the next RESP; they are meaningful only when Ack=1.

Reset
REQ-028 While RST=1:
- FSM = IDLE;
- Tgt_Req = 0, Ack = 0, Err = 0, Busy = 0;
- RData = 0, Tgt_Addr = 0, Tgt_WData = 0, Tgt_WE = 0;
- timeout counter = 0.
REQ-029 Reset asserted mid-transaction abandons it; no Ack is produced for that transaction.

Configuration
REQ-030 Macro MIPS_BUS_TIMEOUT_EN defined: a counter clears on entry to ISSUE and increments each ISSUE cycle. If TIMEOUT_CYCLES cycles pass without the selected Ack:
- drop Tgt_Req;
- go to RESP with Err=1, RData=0.
REQ-031 MIPS_BUS_TIMEOUT_EN undefined: no counter exists, ISSUE waits indefinitely, and Err is raised only by decode errors.

Structure
REQ-032 Package mips_bus_pkg holds:
- the FSM state enum;
- the region nibble constants (4'h0, 4'h1, 4'h2);
- the one-hot select constants.
REQ-033 Sub-module mips_bus_addr_decode: combinational Addr[31:28] -> one-hot select plus decode-error flag.

Verification
REQ-034 RAM read: Addr=0x0000_0010, WE=0, Tgt_RData_A=0xDEAD_BEEF, Ack same cycle -> Tgt_Req=3'b001 at N+1; Ack=1, Err=0, RData=0xDEAD_BEEF at N+2.
REQ-035 IO write: Addr=0x1000_0004, WData=0x0000_00A5, Tgt_Ack[1] after 3 wait cycles -> Tgt_Req=3'b010 for 4 cycles, Tgt_WData=0xA5, Tgt_WE=1; Ack=1, RData=0.
REQ-036 Decode error: Addr=0x7000_0000 -> Tgt_Req never set; Ack=1, Err=1 at N+1.
REQ-037 Stray acks and busy requests:
- Tgt_Ack=3'b101 while the IO target is selected -> ignored;
- second Req while Busy=1 -> ignored;
- only one Ack results.
REQ-038 Timeout (MIPS_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16): timer read with no Tgt_Ack -> Tgt_Req drops after 16 ISSUE cycles; Ack=1, Err=1.
REQ-039 Reset mid-ISSUE: RST=1 while waiting for Tgt_Ack -> Tgt_Req=0, Busy=0 immediately; no Ack after reset is released.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// ---------------------------------------------------------------------------
// mips_bus_pkg
// Shared definitions for the three-target bus demultiplexer:
//   - FSM state encoding (IDLE / ISSUE / RESP)
//   - address region nibbles (Addr[31:28]) for RAM, IO and timer
//   - one-hot target select constants (bit0 RAM, bit1 IO, bit2 timer)
// ---------------------------------------------------------------------------
package mips_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } bus_state_t;

   localparam logic [3:0] REGION_RAM   = 4'h0;
   localparam logic [3:0] REGION_IO    = 4'h1;
   localparam logic [3:0] REGION_TIMER = 4'h2;

   localparam logic [2:0] SEL_NONE  = 3'b000;
   localparam logic [2:0] SEL_RAM   = 3'b001;
   localparam logic [2:0] SEL_IO    = 3'b010;
   localparam logic [2:0] SEL_TIMER = 3'b100;

endpackage

// File: rtl/mips_bus_demux3_if.sv
// ---------------------------------------------------------------------------
// mips_bus_demux3_if
// Bundles the initiator-side and target-side signals of the demultiplexer.
//   Initiator: Req, Addr, WData, WE -> ; <- RData, Ack, Err, Busy
//   Targets  : <- Tgt_Req, Tgt_Addr, Tgt_WData, Tgt_WE ; Tgt_RData_A/B/C,
//              Tgt_Ack ->
// Modports:
//   master : the surroundings (initiator plus targets), drives requests/acks
//   slave  : the demultiplexer itself
// ---------------------------------------------------------------------------
interface mips_bus_demux3_if #(
   parameter int WIDTH = 32
);
   logic              Req;
   logic [31:0]       Addr;
   logic [WIDTH-1:0]  WData;
   logic              WE;
   logic [WIDTH-1:0]  RData;
   logic              Ack;
   logic              Err;
   logic              Busy;
   logic [2:0]        Tgt_Req;
   logic [31:0]       Tgt_Addr;
   logic [WIDTH-1:0]  Tgt_WData;
   logic              Tgt_WE;
   logic [WIDTH-1:0]  Tgt_RData_A;
   logic [WIDTH-1:0]  Tgt_RData_B;
   logic [WIDTH-1:0]  Tgt_RData_C;
   logic [2:0]        Tgt_Ack;

   modport master (
      output Req, Addr, WData, WE, Tgt_RData_A, Tgt_RData_B, Tgt_RData_C, Tgt_Ack,
      input  RData, Ack, Err, Busy, Tgt_Req, Tgt_Addr, Tgt_WData, Tgt_WE
   );

   modport slave (
      input  Req, Addr, WData, WE, Tgt_RData_A, Tgt_RData_B, Tgt_RData_C, Tgt_Ack,
      output RData, Ack, Err, Busy, Tgt_Req, Tgt_Addr, Tgt_WData, Tgt_WE
   );
endinterface

// File: rtl/mips_bus_addr_decode.sv
// ---------------------------------------------------------------------------
// mips_bus_addr_decode
// Combinational region decode of the top address nibble.
//   i_region : Addr[31:28]
//   o_sel    : one-hot target select (SEL_NONE on a decode error)
//   o_err    : 1 when the nibble maps to no target
// ---------------------------------------------------------------------------
module mips_bus_addr_decode
   import mips_bus_pkg::*;
(
   input  logic [3:0] i_region,
   output logic [2:0] o_sel,
   output logic       o_err
);

   // Map region nibble to target select.
   always_comb begin
      o_sel = SEL_NONE;
      o_err = 1'b0;
      case (i_region)
         REGION_RAM:   o_sel = SEL_RAM;
         REGION_IO:    o_sel = SEL_IO;
         REGION_TIMER: o_sel = SEL_TIMER;
         default:      o_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_bus_demux3.sv
// ---------------------------------------------------------------------------
// mips_bus_demux3
// Single-initiator to three-target bus demultiplexer (RAM, IO, timer).
// A request is accepted only in IDLE, its fields are latched, the decoded
// target is requested until it acks, and a one-cycle Ack (with Err) returns
// to the initiator. All outputs are registered.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : mips_bus_demux3_if.slave (initiator and target signals)
// Optional feature: define MIPS_BUS_TIMEOUT_EN to abort a target that does
// not ack within TIMEOUT_CYCLES ISSUE cycles (Ack with Err=1, RData=0).
// ---------------------------------------------------------------------------
module mips_bus_demux3
   import mips_bus_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   mips_bus_demux3_if.slave     bus
);

   bus_state_t        r_state;
   logic [2:0]        r_sel;
   logic [2:0]        r_tgt_req;
   logic [31:0]       r_addr;
   logic [WIDTH-1:0]  r_wdata;
   logic              r_we;
   logic [WIDTH-1:0]  r_rdata;
   logic              r_ack;
   logic              r_err;
   logic              r_busy;

   logic [2:0]        w_sel;
   logic              w_dec_err;
   logic              w_hit;
   logic [WIDTH-1:0]  w_tgt_rdata;

`ifdef MIPS_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0]  r_cnt;
`endif

   mips_bus_addr_decode u_decode (
      .i_region (bus.Addr[31:28]),
      .o_sel    (w_sel),
      .o_err    (w_dec_err)
   );

   // Only the latched target's ack bit counts; stray bits are masked off.
   assign w_hit = |(bus.Tgt_Ack & r_sel);

   // Select read data from the latched target.
   always_comb begin
      w_tgt_rdata = '0;
      case (r_sel)
         SEL_RAM:   w_tgt_rdata = bus.Tgt_RData_A;
         SEL_IO:    w_tgt_rdata = bus.Tgt_RData_B;
         SEL_TIMER: w_tgt_rdata = bus.Tgt_RData_C;
         default:   w_tgt_rdata = '0;
      endcase
   end

   // Transaction FSM with registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_sel     <= SEL_NONE;
         r_tgt_req <= 3'b000;
         r_addr    <= 32'h0000_0000;
         r_wdata   <= '0;
         r_we      <= 1'b0;
         r_rdata   <= '0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
`ifdef MIPS_BUS_TIMEOUT_EN
         r_cnt     <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.Req) begin
                  r_addr  <= bus.Addr;
                  r_wdata <= bus.WData;
                  r_we    <= bus.WE;
                  r_sel   <= w_sel;
                  r_busy  <= 1'b1;
                  if (w_dec_err) begin
                     // Decode error answers directly, no target is touched.
                     r_state <= ST_RESP;
                     r_ack   <= 1'b1;
                     r_err   <= 1'b1;
                     r_rdata <= '0;
                  end else begin
                     r_state   <= ST_ISSUE;
                     r_tgt_req <= w_sel;
`ifdef MIPS_BUS_TIMEOUT_EN
                     r_cnt     <= '0;
`endif
                  end
               end
            end
            ST_ISSUE: begin
               if (w_hit) begin
                  r_state   <= ST_RESP;
                  r_tgt_req <= 3'b000;
                  r_ack     <= 1'b1;
                  r_err     <= 1'b0;
                  r_rdata   <= r_we ? '0 : w_tgt_rdata;
               end
`ifdef MIPS_BUS_TIMEOUT_EN
               else if (r_cnt == CNT_LAST) begin
                  r_state   <= ST_RESP;
                  r_tgt_req <= 3'b000;
                  r_ack     <= 1'b1;
                  r_err     <= 1'b1;
                  r_rdata   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               r_ack   <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_tgt_req <= 3'b000;
               r_ack     <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.RData     = r_rdata;
   assign bus.Ack       = r_ack;
   assign bus.Err       = r_err;
   assign bus.Busy      = r_busy;
   assign bus.Tgt_Req   = r_tgt_req;
   assign bus.Tgt_Addr  = r_addr;
   assign bus.Tgt_WData = r_wdata;
   assign bus.Tgt_WE    = r_we;

endmodule

// File: tb/tb_mips_bus_demux3.sv
// ---------------------------------------------------------------------------
// tb_mips_bus_demux3
// Directed bench for mips_bus_demux3. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_bus_demux3;

   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mips_bus_demux3_if #(.WIDTH(WIDTH)) bus ();

   mips_bus_demux3 #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(16)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.Req   = 1'b0;
      bus.Addr  = 32'h0;
      bus.WData = 32'h0;
      bus.WE    = 1'b0;
      bus.Tgt_Ack = 3'b000;
   endtask

   initial begin
      idle_inputs();
      bus.Tgt_RData_A = 32'h0;
      bus.Tgt_RData_B = 32'h0;
      bus.Tgt_RData_C = 32'h0;
      bus.Req = 1'b1;           // request during reset must be ignored
      bus.Addr = 32'h0000_0010;
      step(); step();
      check_val("rst_ack",   {63'd0, bus.Ack},  64'd0);
      check_val("rst_err",   {63'd0, bus.Err},  64'd0);
      check_val("rst_busy",  {63'd0, bus.Busy}, 64'd0);
      check_val("rst_treq",  {61'd0, bus.Tgt_Req}, 64'd0);
      check_val("rst_rdata", {32'd0, bus.RData}, 64'd0);
      check_val("rst_taddr", {32'd0, bus.Tgt_Addr}, 64'd0);
      check_val("rst_twe",   {63'd0, bus.Tgt_WE}, 64'd0);
      idle_inputs();
      rst = 1'b0;
      step();

      // RAM read, ack in the first ISSUE cycle.
      bus.Req = 1'b1; bus.Addr = 32'h0000_0010; bus.WE = 1'b0;
      bus.Tgt_RData_A = 32'hDEAD_BEEF;
      step();
      bus.Req = 1'b0; bus.Addr = 32'hFFFF_FFFF; bus.WE = 1'b1;   // fields need not be held
      check_val("ram_treq",  {61'd0, bus.Tgt_Req}, 64'h1);
      check_val("ram_busy",  {63'd0, bus.Busy}, 64'd1);
      check_val("ram_ack0",  {63'd0, bus.Ack}, 64'd0);
      check_val("ram_taddr", {32'd0, bus.Tgt_Addr}, 64'h10);
      check_val("ram_twe",   {63'd0, bus.Tgt_WE}, 64'd0);
      bus.Tgt_Ack = 3'b001;
      step();
      bus.Tgt_Ack = 3'b000;
      check_val("ram_ack",   {63'd0, bus.Ack}, 64'd1);
      check_val("ram_err",   {63'd0, bus.Err}, 64'd0);
      check_val("ram_rdata", {32'd0, bus.RData}, 64'hDEAD_BEEF);
      check_val("ram_treq_drop", {61'd0, bus.Tgt_Req}, 64'h0);
      step();
      check_val("ram_ack_end", {63'd0, bus.Ack}, 64'd0);
      check_val("ram_busy_end", {63'd0, bus.Busy}, 64'd0);
      check_val("ram_rdata_hold", {32'd0, bus.RData}, 64'hDEAD_BEEF);
      idle_inputs();

      // Decode error.
      bus.Req = 1'b1; bus.Addr = 32'h7000_0000;
      step();
      bus.Req = 1'b0;
      check_val("dec_ack",   {63'd0, bus.Ack}, 64'd1);
      check_val("dec_err",   {63'd0, bus.Err}, 64'd1);
      check_val("dec_rdata", {32'd0, bus.RData}, 64'd0);
      check_val("dec_treq",  {61'd0, bus.Tgt_Req}, 64'h0);
      check_val("dec_busy",  {63'd0, bus.Busy}, 64'd1);
      step();
      check_val("dec_ack_end", {63'd0, bus.Ack}, 64'd0);
      check_val("dec_treq2", {61'd0, bus.Tgt_Req}, 64'h0);
      check_val("dec_err_hold", {63'd0, bus.Err}, 64'd1);

      // IO write, target acks in the 4th ISSUE cycle.
      bus.Req = 1'b1; bus.Addr = 32'h1000_0004; bus.WData = 32'h0000_00A5; bus.WE = 1'b1;
      bus.Tgt_RData_B = 32'h5555_5555;
      step();
      bus.Req = 1'b0; bus.Addr = 32'h0; bus.WData = 32'h0; bus.WE = 1'b0;
      check_val("io_twdata", {32'd0, bus.Tgt_WData}, 64'hA5);
      check_val("io_twe",    {63'd0, bus.Tgt_WE}, 64'd1);
      check_val("io_taddr",  {32'd0, bus.Tgt_Addr}, 64'h1000_0004);
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("io_treq_c%0d", i), {61'd0, bus.Tgt_Req}, 64'h2);
         check_val($sformatf("io_noack_c%0d", i), {63'd0, bus.Ack}, 64'd0);
         if (i == 3) bus.Tgt_Ack = 3'b010;
         step();
      end
      bus.Tgt_Ack = 3'b000;
      check_val("io_ack",   {63'd0, bus.Ack}, 64'd1);
      check_val("io_err",   {63'd0, bus.Err}, 64'd0);
      check_val("io_rdata", {32'd0, bus.RData}, 64'd0);
      check_val("io_treq_drop", {61'd0, bus.Tgt_Req}, 64'h0);
      step();

      // IO read with stray acks and a request while busy.
      bus.Req = 1'b1; bus.Addr = 32'h1000_0008; bus.WE = 1'b0;
      bus.Tgt_RData_A = 32'h0000_AAAA; bus.Tgt_RData_B = 32'h1234_5678; bus.Tgt_RData_C = 32'h0000_CCCC;
      step();
      bus.Req = 1'b1; bus.Addr = 32'h0000_0000;     // ignored: busy
      bus.Tgt_Ack = 3'b101;                         // ignored: not selected
      step();
      check_val("stray_treq", {61'd0, bus.Tgt_Req}, 64'h2);
      check_val("stray_noack", {63'd0, bus.Ack}, 64'd0);
      bus.Req = 1'b0;
      bus.Tgt_Ack = 3'b010;
      step();
      bus.Tgt_Ack = 3'b000;
      check_val("stray_ack",   {63'd0, bus.Ack}, 64'd1);
      check_val("stray_rdata", {32'd0, bus.RData}, 64'h1234_5678);
      check_val("stray_err",   {63'd0, bus.Err}, 64'd0);
      bus.Tgt_Ack = 3'b111;                         // acks in IDLE are ignored
      for (int i = 0; i < 4; i++) begin
         step();
         check_val($sformatf("stray_single_ack_c%0d", i), {63'd0, bus.Ack}, 64'd0);
         check_val($sformatf("stray_no_queue_c%0d", i), {61'd0, bus.Tgt_Req}, 64'h0);
      end
      check_val("stray_idle_busy", {63'd0, bus.Busy}, 64'd0);
      idle_inputs();

      // Timer read with no target ack.
      bus.Req = 1'b1; bus.Addr = 32'h2000_0000; bus.WE = 1'b0;
      step();
      bus.Req = 1'b0;
`ifdef MIPS_BUS_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         check_val($sformatf("to_treq_c%0d", i), {61'd0, bus.Tgt_Req}, 64'h4);
         check_val($sformatf("to_noack_c%0d", i), {63'd0, bus.Ack}, 64'd0);
         step();
      end
      check_val("to_ack",   {63'd0, bus.Ack}, 64'd1);
      check_val("to_err",   {63'd0, bus.Err}, 64'd1);
      check_val("to_rdata", {32'd0, bus.RData}, 64'd0);
      check_val("to_treq_drop", {61'd0, bus.Tgt_Req}, 64'h0);
      step();
`else
      for (int i = 0; i < 20; i++) step();
      check_val("wait_treq", {61'd0, bus.Tgt_Req}, 64'h4);
      check_val("wait_busy", {63'd0, bus.Busy}, 64'd1);
      check_val("wait_noack", {63'd0, bus.Ack}, 64'd0);
      bus.Tgt_RData_C = 32'h0BAD_F00D;
      bus.Tgt_Ack = 3'b100;
      step();
      bus.Tgt_Ack = 3'b000;
      check_val("wait_ack",   {63'd0, bus.Ack}, 64'd1);
      check_val("wait_err",   {63'd0, bus.Err}, 64'd0);
      check_val("wait_rdata", {32'd0, bus.RData}, 64'h0BAD_F00D);
      step();
`endif

      // Reset while waiting in ISSUE.
      bus.Req = 1'b1; bus.Addr = 32'h2000_0040; bus.WE = 1'b0;
      step();
      bus.Req = 1'b0;
      check_val("mid_treq", {61'd0, bus.Tgt_Req}, 64'h4);
      rst = 1'b1;
      #1;
      check_val("mid_rst_treq",  {61'd0, bus.Tgt_Req}, 64'h0);
      check_val("mid_rst_busy",  {63'd0, bus.Busy}, 64'd0);
      check_val("mid_rst_taddr", {32'd0, bus.Tgt_Addr}, 64'h0);
      check_val("mid_rst_rdata", {32'd0, bus.RData}, 64'h0);
      step();
      rst = 1'b0;
      bus.Tgt_Ack = 3'b100;
      for (int i = 0; i < 4; i++) begin
         step();
         check_val($sformatf("mid_noack_c%0d", i), {63'd0, bus.Ack}, 64'd0);
      end
      check_val("mid_busy_after", {63'd0, bus.Busy}, 64'd0);
      idle_inputs();
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
